// File: rtl/seg_addr_pkg.sv
// seg_addr_pkg: shared state codes, segment indices and reset defaults for seg_addr_gen.
package seg_addr_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT = 2'd1;
  localparam logic [1:0] SPLIT1 = 2'd2;
  localparam int ES = 0;
  localparam int CS = 1;
  localparam int SS = 2;
  localparam int DS = 3;
  localparam logic [15:0] CS_RST_DEF = 16'hFFFF;
endpackage

// File: rtl/linear_addr_calc.sv
// linear_addr_calc: combinational (segment << SHIFT) + offset, truncated to ADDR_W.
module linear_addr_calc #(
  parameter int SEG_W = 16,
  parameter int OFS_W = 16,
  parameter int SHIFT = 4,
  parameter int ADDR_W = 20
) (
  input  logic [SEG_W-1:0]  seg,
  input  logic [OFS_W-1:0]  ofs,
  output logic [ADDR_W-1:0] addr
);
  localparam int SW = (SEG_W + SHIFT > OFS_W) ? SEG_W + SHIFT : OFS_W;
  localparam int W = ((SW > ADDR_W) ? SW : ADDR_W) + 1;
  logic [W-1:0] sh, of;
  assign sh = W'({seg, {SHIFT{1'b0}}});
  assign of = W'(ofs);
  assign addr = ADDR_W'(sh + of);
endmodule

// File: rtl/seg_addr_gen.sv
// seg_addr_gen: segment register file plus registered segment:offset address generator
// that splits odd-offset word accesses into two byte beats.
module seg_addr_gen
  import seg_addr_pkg::*;
#(
  parameter int SEG_W = 16,
  parameter int OFS_W = 16,
  parameter int SHIFT = 4,
  parameter int ADDR_W = 20,
  parameter int NSEG = 4,
  parameter int SEL_W = $clog2(NSEG),
  parameter logic [SEG_W-1:0] CS_RST = SEG_W'(CS_RST_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seg_we,
  input  logic [SEL_W-1:0]  seg_wsel,
  input  logic [SEG_W-1:0]  seg_wdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [OFS_W-1:0]  req_offset,
  input  logic              req_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_word,
  output logic              out_last
);
  logic [1:0]        state;
  logic [SEG_W-1:0]  seg_r [NSEG];
  logic [SEG_W-1:0]  cap_seg, calc_seg;
  logic [OFS_W-1:0]  cap_ofs, calc_ofs;
  logic [ADDR_W-1:0] calc_addr;
  logic              acc, split;
  assign req_ready = state == IDLE || (state == BEAT && out_ready);
  assign out_valid = state != IDLE;
  assign acc = req_valid && req_ready;
  assign split = req_word && req_offset[0];
  // a new request reads the pre-edge segment; otherwise compute beat 2 from the captured pair
  assign calc_seg = acc ? seg_r[req_sel] : cap_seg;
  assign calc_ofs = acc ? req_offset : cap_ofs + OFS_W'(1);
  linear_addr_calc #(.SEG_W(SEG_W), .OFS_W(OFS_W), .SHIFT(SHIFT), .ADDR_W(ADDR_W)) u_calc (
    .seg(calc_seg),
    .ofs(calc_ofs),
    .addr(calc_addr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) seg_r[i] <= (i == CS) ? CS_RST : '0;
    end else if (seg_we) begin
      seg_r[seg_wsel] <= seg_wdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_addr <= '0;
      out_word <= 1'b0;
      out_last <= 1'b0;
      cap_seg <= '0;
      cap_ofs <= '0;
    end else if (acc) begin
      state <= split ? SPLIT1 : BEAT;
      out_addr <= calc_addr;
      out_word <= req_word && !split;
      out_last <= !split;
      cap_seg <= calc_seg;
      cap_ofs <= req_offset;
    end else if (state == SPLIT1 && out_ready) begin
      state <= BEAT;
      out_addr <= calc_addr;
      out_word <= 1'b0;
      out_last <= 1'b1;
    end else if (state == BEAT && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_seg_addr_gen.sv
// tb_seg_addr_gen: directed plan plus random traffic against a beat-queue reference model.
module tb_seg_addr_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seg_we = 1'b0;
  logic [1:0]  seg_wsel = '0;
  logic [15:0] seg_wdata = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = '0;
  logic [15:0] req_offset = '0;
  logic        req_word = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_addr;
  logic        out_word;
  logic        out_last;

  typedef struct {
    logic [19:0] a;
    bit w;
    bit l;
  } beat_t;

  beat_t q[$];
  int segs[4];
  int n_chk = 0;
  int n_fail = 0;

  seg_addr_gen dut (
    .clk(clk), .rst_n(rst_n),
    .seg_we(seg_we), .seg_wsel(seg_wsel), .seg_wdata(seg_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_offset(req_offset), .req_word(req_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_word(out_word), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] lin(input int s, input int o);
    logic [31:0] t;
    t = (s << 4) + (o & 'hFFFF);
    return t[19:0];
  endfunction

  function automatic void model_reset();
    q.delete();
    segs = '{0, 'hFFFF, 0, 0};
  endfunction

  task automatic step(input bit we, input int wsel, input int wdata, input bit v,
                      input int sel, input int ofs, input bit w, input bit ordy);
    bit rdy;
    int s;
    seg_we = we;
    seg_wsel = 2'(wsel);
    seg_wdata = 16'(wdata);
    req_valid = v;
    req_sel = 2'(sel);
    req_offset = 16'(ofs);
    req_word = w;
    out_ready = ordy;
    #1;
    rdy = q.size() == 0 || (q.size() == 1 && ordy);
    chk("req_ready", 32'(req_ready), 32'(rdy));
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (v && rdy) begin
      s = segs[sel];
      if (w && ofs[0]) begin
        q.push_back('{lin(s, ofs), 1'b0, 1'b0});
        q.push_back('{lin(s, ofs + 1), 1'b0, 1'b1});
      end else begin
        q.push_back('{lin(s, ofs), w, 1'b1});
      end
    end
    if (we) segs[wsel] = wdata & 'hFFFF;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_addr", 32'(out_addr), 32'(q[0].a));
      chk("out_word", 32'(out_word), 32'(q[0].w));
      chk("out_last", 32'(out_last), 32'(q[0].l));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 1, 1, 0, 0, 1);
    chk("cs_reset_addr", 32'(out_addr), 32'hFFFF0);
    chk("cs_reset_last", 32'(out_last), 32'd1);
    idle(1);
    step(1, 3, 'h1234, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 3, 'h10, 0, 1);
    chk("ds_addr", 32'(out_addr), 32'h12350);
    step(1, 2, 'hFFFF, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 2, 'h10, 0, 1);
    chk("ss_trunc", 32'(out_addr), 32'h00000);
    step(1, 0, 'h2000, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 'hFFFF, 1, 1);
    chk("split_b1", 32'(out_addr), 32'h2FFFF);
    chk("split_b1_ready", 32'(req_ready), 32'd0);
    step(0, 0, 0, 1, 1, 0, 0, 1);
    chk("split_b2_wrap", 32'(out_addr), 32'h20000);
    idle(1);
    step(1, 0, 'h1000, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 'h0100, 1, 0);
    chk("even_word", 32'(out_word), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3, 'h22, 0, 0);
    chk("hold_addr", 32'(out_addr), 32'h10100);
    idle(2);
    step(1, 3, 'h5555, 1, 3, 0, 0, 1);
    chk("same_cycle_old", 32'(out_addr), 32'h12340);
    step(0, 0, 0, 1, 3, 0, 0, 1);
    chk("same_cycle_new", 32'(out_addr), 32'h55550);
    idle(1);
    step(0, 0, 0, 1, 0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_addr", 32'(out_addr), 32'd0);
    chk("async_last", 32'(out_last), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd1);
    model_reset();
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    step(0, 0, 0, 1, 1, 0, 0, 1);
    chk("cs_after_rst", 32'(out_addr), 32'hFFFF0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom & 'hFFFF,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0) ? 'hFFFF : ($urandom & 'hFFFF),
           $urandom_range(0, 1), $urandom_range(0, 3) != 0);
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
